multiword_add_seq: RTL and testbench

Sequencer that performs a WORDS×W-bit addition on the team's W-bit pipelined ripple-carry adder by issuing one W-bit chunk at a time, LSB chunk first. It chains each chunk's carry-out into the next chunk's carry-in. It sits directly upstream of the adder (driving its operands and carry-in) and directly downstream of it (capturing sum and carry-out). It presents a valid/ready interface to the surrounding datapath.

---
 rtl/adder_pkg.sv | 11 +
 rtl/multiword_add_seq_if.sv | 39 +++
 rtl/mwadd_chunk_mux.sv | 32 +++
 rtl/multiword_add_seq.sv | 120 ++++++++++++
 tb/tb_multiword_add_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multiword adder sequencer: sequencer state encoding and default chunk width.
package adder_pkg;

    localparam int DEF_W = 64;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/response handshake bundle of the multiword adder sequencer.
// Optional out_ovf exists only when MULTIWORD_ADD_SEQ_OVF_EN is defined.
interface multiword_add_seq_if
    import adder_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WORDS = 4
);

    logic               in_valid;
    logic               in_ready;
    logic [W*WORDS-1:0] in_a;
    logic [W*WORDS-1:0] in_b;
    logic               in_cin;
    logic               out_valid;
    logic               out_ready;
    logic [W*WORDS-1:0] out_sum;
    logic               out_cout;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    logic               out_ovf;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/mwadd_chunk_mux.sv
// Selects chunk idx of the latched operands for the adder; drives zeros
// whenever no chunk is being issued.
module mwadd_chunk_mux
    import adder_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic               issue,
    input  logic [IDX_W-1:0]   idx,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic               cy,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_cin
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (issue) begin
            add_a   = a[idx*W +: W];
            add_b   = b[idx*W +: W];
            add_cin = cy;
        end
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequences a WORDS x W-bit add through an external ADD_LAT-cycle W-bit adder, LSB chunk first.
// Define MULTIWORD_ADD_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module multiword_add_seq
    import adder_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    multiword_add_seq_if.slave  bus,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    output logic                add_cin,
    input  logic [W-1:0]        add_sum,
    input  logic                add_cout
);

    localparam int FW    = W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_LAT - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             cy;
    logic [FW-1:0]    a_lat;
    logic [FW-1:0]    b_lat;
    logic [FW-1:0]    res;
    logic             capture;

    // The adder output is only trusted ADD_LAT cycles after our own issue.
    assign capture = (state == WAIT) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            a_lat <= '0;
            b_lat <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_lat <= bus.in_a;
                        b_lat <= bus.in_b;
                        cy    <= bus.in_cin;
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        res[idx*W +: W] <= add_sum;
                        cy              <= add_cout;
                        if (idx == IDX_LAST) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    logic ovf;

    // Signed overflow: equal operand signs but a result sign that differs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (capture && (idx == IDX_LAST)) begin
            ovf <= (a_lat[FW-1] == b_lat[FW-1]) && (add_sum[W-1] != a_lat[FW-1]);
        end
    end

    assign bus.out_ovf = ovf;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = res;
    assign bus.out_cout  = cy;

    mwadd_chunk_mux #(
        .W     (W),
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_chunk_mux (
        .issue   (state == ISSUE),
        .idx     (idx),
        .a       (a_lat),
        .b       (b_lat),
        .cy      (cy),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin)
    );

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: a two-stage pipelined 64-bit adder model
// feeds the sequencer; results are compared with wide arithmetic done in the bench.
module tb_multiword_add_seq;

    localparam int W       = 64;
    localparam int WORDS   = 4;
    localparam int ADD_LAT = 2;
    localparam int FW      = W * WORDS;
    localparam int STEP    = ADD_LAT + 1;
    localparam int BUSY    = WORDS * STEP;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    int n_checks = 0;
    int n_errors = 0;

    multiword_add_seq_if #(.W(W), .WORDS(WORDS)) bus();

    multiword_add_seq #(.W(W), .WORDS(WORDS), .ADD_LAT(ADD_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    always #5 clk = ~clk;

    // Ripple adder with input and output pipeline registers.
    logic [W-1:0] p_a = '0, p_b = '0;
    logic         p_c = 1'b0;
    initial begin
        add_sum  = '0;
        add_cout = 1'b0;
    end
    always @(posedge clk) begin
        p_a <= add_a;
        p_b <= add_b;
        p_c <= add_cin;
        {add_cout, add_sum} <= {1'b0, p_a} + {1'b0, p_b} + (W+1)'(p_c);
    end

    task automatic check(input string tag, input logic [FW:0] got, input logic [FW:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW:0] ref_add(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + (FW+1)'(cin);
    endfunction

    // Carry into chunk k is bit k*W of the sum of the operands truncated below chunk k.
    function automatic logic carry_into(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                        input logic cin, input int k);
        logic [FW:0] m, s;
        if (k == 0) return cin;
        m = ((FW+1)'(1) << (k * W)) - (FW+1)'(1);
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + (FW+1)'(cin);
        return s[k*W];
    endfunction

    function automatic logic [FW-1:0] rand_word();
        logic [FW-1:0] v;
        logic [W-1:0]  ch;
        for (int k = 0; k < WORDS; k++) begin
            case ($urandom_range(0, 3))
                0:       ch = '0;
                1:       ch = '1;
                default: ch = {$urandom, $urandom};
            endcase
            v[k*W +: W] = ch;
        end
        return v;
    endfunction

    task automatic drive_junk();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_a     = rand_word();
        bus.in_b     = rand_word();
        bus.in_cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_sum"},   bus.out_sum, 0);
        check({tag, "_out_cout"},  bus.out_cout, 0);
        check({tag, "_add"},       {add_a, add_b, add_cin}, 0);
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        check({tag, "_out_ovf"},   bus.out_ovf, 0);
`endif
    endtask

    // Accept at cycle T, follow every busy cycle, hold DONE for `hold` cycles, then handshake.
    task automatic run_op(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic cin,
                          input int hold);
        logic [FW:0] exp;
        logic        exp_ovf;
        int          k;
        exp     = ref_add(a, b, cin);
        exp_ovf = (a[FW-1] == b[FW-1]) && (exp[FW-1] != a[FW-1]);
        @(negedge clk);
        check("accept_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        for (int c = 1; c <= BUSY; c++) begin
            @(negedge clk);
            check("busy_out_valid", bus.out_valid, 0);
            check("busy_in_ready", bus.in_ready, 0);
            if ((c - 1) % STEP == 0) begin
                k = (c - 1) / STEP;
                check("issue_add_a", add_a, a[k*W +: W]);
                check("issue_add_b", add_b, b[k*W +: W]);
                check("issue_add_cin", add_cin, carry_into(a, b, cin, k));
            end else begin
                check("wait_add_zero", {add_a, add_b, add_cin}, 0);
            end
            drive_junk();
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            check("done_out_valid", bus.out_valid, 1);
            check("done_in_ready", bus.in_ready, 0);
            check("done_out_sum", bus.out_sum, exp[FW-1:0]);
            check("done_out_cout", bus.out_cout, exp[FW]);
            check("done_add_zero", {add_a, add_b, add_cin}, 0);
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
            check("done_out_ovf", bus.out_ovf, exp_ovf);
`endif
            if (h < hold) begin
                drive_junk();
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_in_ready", bus.in_ready, 1);
        check("post_out_valid", bus.out_valid, 0);
    endtask

    // Start an op, assert rst (together with in_valid) in cycle T+6, check reset values at T+7.
    task automatic run_reset_mid(input logic [FW-1:0] a, input logic [FW-1:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] a, b;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        run_op(FW'(1), FW'(0), 1'b0, 0);
        a = '1;
        run_op(a, FW'(0), 1'b1, 2);
        a = '0;
        a[W-1:0]    = '1;
        a[2*W-1:W]  = W'(1);
        run_op(a, FW'(1), 1'b0, 0);
        run_op(rand_word(), rand_word(), 1'b1, 5);

        run_reset_mid(rand_word(), rand_word());
        run_op(FW'(5), FW'(7), 1'b0, 1);

        a = '1;
        a[FW-1] = 1'b0;
        run_op(a, FW'(1), 1'b0, 0);
        a = '0;
        a[FW-1] = 1'b1;
        run_op(a, a, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            a = rand_word();
            b = rand_word();
            run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
